mfc_operand_sequencer: RTL and testbench

- Sits upstream of and around the 16-bit multi-function comparator (eq / ae / gt / d[3:0]).
- Assembles signed 16-bit operand pairs A, B from a byte stream and drives them onto the comparator inputs, holding them stable.
- Waits a programmable settle time, then captures the comparator flags into a result register with a valid/ready handshake.
- Keeps running counts of equal and greater-than results for system status.

---
 rtl/mfc_operand_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mfc_operand_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mfc_operand_sequencer.sv
// mfc_operand_sequencer: assembles signed 16-bit operand pairs from a byte
// stream, drives them onto the multi-function comparator, waits a settle
// time, captures the comparator flags behind a valid/ready handshake, and
// keeps saturating counts of equal and greater-than results.
module mfc_operand_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 50,  // 1..255
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      cmp_a,
  output logic [15:0]      cmp_b,
  input  logic             cmp_eq,
  input  logic             cmp_ae,
  input  logic             cmp_gt,
  input  logic [3:0]       cmp_d,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [6:0]       res_flags,
  output logic [CNT_W-1:0] res_idx,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] gt_count
);

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    RESULT
  } state_t;

  state_t            state_q,     state_d;
  logic [1:0]        byte_cnt_q,  byte_cnt_d;
  logic [23:0]       stage_q,     stage_d;
  logic [7:0]        settle_q,    settle_d;
  logic [15:0]       cmp_a_q,     cmp_a_d;
  logic [15:0]       cmp_b_q,     cmp_b_d;
  logic              in_ready_q,  in_ready_d;
  logic              res_valid_q, res_valid_d;
  logic [6:0]        res_flags_q, res_flags_d;
  logic [CNT_W-1:0]  res_idx_q,   res_idx_d;
  logic [CNT_W-1:0]  eq_count_q,  eq_count_d;
  logic [CNT_W-1:0]  gt_count_q,  gt_count_d;

  // Next-state and datapath: byte assembly, settle countdown, result handshake.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    stage_d     = stage_q;
    settle_d    = settle_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    in_ready_d  = in_ready_q;
    res_valid_d = res_valid_q;
    res_flags_d = res_flags_q;
    res_idx_d   = res_idx_q;
    eq_count_d  = eq_count_q;
    gt_count_d  = gt_count_q;

    if (flush) begin
      // Abort wins over any accept or handshake on the same edge.
      state_d     = LOAD;
      byte_cnt_d  = '0;
      stage_d     = '0;
      res_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      unique case (state_q)
        LOAD: begin
          in_ready_d = 1'b1;
          if (in_valid && in_ready_q) begin
            unique case (byte_cnt_q)
              2'd0: stage_d[7:0]   = in_data;
              2'd1: stage_d[15:8]  = in_data;
              2'd2: stage_d[23:16] = in_data;
              default: ;
            endcase
            if (byte_cnt_q == 2'd3) begin
              // Both operands switch on one edge so the comparator never
              // sees a half-updated pair.
              cmp_a_d    = stage_q[15:0];
              cmp_b_d    = {in_data, stage_q[23:16]};
              byte_cnt_d = '0;
              settle_d   = 8'(SETTLE_CYCLES - 1);
              in_ready_d = 1'b0;
              state_d    = SETTLE;
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end
        end

        SETTLE: begin
          in_ready_d = 1'b0;
          if (settle_q == '0) begin
            res_flags_d = {cmp_d, cmp_gt, cmp_ae, cmp_eq};
            res_valid_d = 1'b1;
            state_d     = RESULT;
          end else begin
            settle_d = settle_q - 8'd1;
          end
        end

        RESULT: begin
          in_ready_d = 1'b0;
          if (res_ready) begin
            res_valid_d = 1'b0;
            res_idx_d   = res_idx_q + CNT_W'(1);
            if (res_flags_q[0] && (eq_count_q != '1)) begin
              eq_count_d = eq_count_q + CNT_W'(1);
            end
            if (res_flags_q[2] && (gt_count_q != '1)) begin
              gt_count_d = gt_count_q + CNT_W'(1);
            end
            in_ready_d = 1'b1;
            state_d    = LOAD;
          end
        end

        default: begin
          state_d    = LOAD;
          byte_cnt_d = '0;
          in_ready_d = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs; async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      byte_cnt_q  <= '0;
      stage_q     <= '0;
      settle_q    <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_flags_q <= '0;
      res_idx_q   <= '0;
      eq_count_q  <= '0;
      gt_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      stage_q     <= stage_d;
      settle_q    <= settle_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_flags_q <= res_flags_d;
      res_idx_q   <= res_idx_d;
      eq_count_q  <= eq_count_d;
      gt_count_q  <= gt_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign cmp_a     = cmp_a_q;
  assign cmp_b     = cmp_b_q;
  assign res_valid = res_valid_q;
  assign res_flags = res_flags_q;
  assign res_idx   = res_idx_q;
  assign eq_count  = eq_count_q;
  assign gt_count  = gt_count_q;

endmodule

// File: tb/tb_mfc_operand_sequencer.sv
// Directed, table-driven bench for mfc_operand_sequencer with a behavioural
// model of the 16-bit multi-function comparator closing the loop.
`timescale 1ns/1ps
module tb_mfc_operand_sequencer;

  localparam int unsigned SETTLE = 50;
  localparam int unsigned CW     = 8;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready;
  logic [7:0]    in_data;
  logic [15:0]   cmp_a, cmp_b;
  logic          cmp_eq, cmp_ae, cmp_gt;
  logic [3:0]    cmp_d;
  logic          res_valid, res_ready;
  logic [6:0]    res_flags;
  logic [CW-1:0] res_idx, eq_count, gt_count;

  int vectors     = 0;
  int miscompares = 0;

  mfc_operand_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_eq(cmp_eq), .cmp_ae(cmp_ae), .cmp_gt(cmp_gt), .cmp_d(cmp_d),
    .res_valid(res_valid), .res_ready(res_ready), .res_flags(res_flags),
    .res_idx(res_idx), .eq_count(eq_count), .gt_count(gt_count)
  );

  always #5 clk = ~clk;

  // Behavioural comparator: eq, |A|==|B|, signed A>B, per-nibble equality.
  logic [16:0] abs_a, abs_b;
  always_comb begin
    abs_a  = cmp_a[15] ? 17'({1'b0, ~cmp_a} + 17'd1) : {1'b0, cmp_a};
    abs_b  = cmp_b[15] ? 17'({1'b0, ~cmp_b} + 17'd1) : {1'b0, cmp_b};
    cmp_eq = (cmp_a == cmp_b);
    cmp_ae = (abs_a == abs_b);
    cmp_gt = ($signed(cmp_a) > $signed(cmp_b));
    cmp_d  = '0;
    for (int i = 0; i < 4; i++) cmp_d[i] = (cmp_a[4*i +: 4] == cmp_b[4*i +: 4]);
  end

  typedef struct {
    logic [15:0]   a;
    logic [15:0]   b;
    logic [6:0]    flags;
    logic [CW-1:0] idx;
    logic [CW-1:0] eqc;  // eq_count after handshake
    logic [CW-1:0] gtc;  // gt_count after handshake
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_cmp_a"},     32'(cmp_a),     0);
    check({tag, "_cmp_b"},     32'(cmp_b),     0);
    check({tag, "_res_flags"}, 32'(res_flags), 0);
    check({tag, "_res_idx"},   32'(res_idx),   0);
    check({tag, "_eq_count"},  32'(eq_count),  0);
    check({tag, "_gt_count"},  32'(gt_count),  0);
  endtask

  // Present a byte and hold it until accepted; returns 1 ns after the accept edge.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Send one pair and wait for its result; lat counts edges from the
  // last-byte accept edge (inclusive) to the edge raising res_valid.
  task automatic run_pair(input logic [15:0] a, input logic [15:0] b,
                          output logic [6:0] flags, output logic [CW-1:0] idx,
                          output int lat);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(b[7:0]);
    send_byte(b[15:8]);
    lat = 1;
    while (!res_valid && lat < int'(SETTLE) + 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!res_valid) check("result_timeout", 0, 1);
    flags = res_flags;
    idx   = res_idx;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]    f;
    logic [CW-1:0] ix;
    int            lat;
    bit            seen;

    //          a         b         flags        idx  eqc  gtc
    tbl[0] = '{16'h0005, 16'h0005, 7'b1111_011, 8'd0, 8'd1, 8'd0};
    tbl[1] = '{16'hFFFB, 16'h0005, 7'b0000_010, 8'd1, 8'd1, 8'd0};
    tbl[2] = '{16'h0005, 16'hFFFB, 7'b0000_110, 8'd2, 8'd1, 8'd1};
    tbl[3] = '{16'h1234, 16'h1235, 7'b1110_000, 8'd3, 8'd1, 8'd1};
    tbl[4] = '{16'h8000, 16'h7FFF, 7'b0000_000, 8'd4, 8'd1, 8'd1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    check("in_ready_before_first_edge", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("in_ready_first_edge", 32'(in_ready), 1);

    // Table of operand pairs.
    for (int i = 0; i < 5; i++) begin
      run_pair(tbl[i].a, tbl[i].b, f, ix, lat);
      check($sformatf("v%0d_latency", i),   32'(lat),   SETTLE + 1);
      check($sformatf("v%0d_flags", i),     32'(f),     32'(tbl[i].flags));
      check($sformatf("v%0d_idx", i),       32'(ix),    32'(tbl[i].idx));
      check($sformatf("v%0d_cmp_a", i),     32'(cmp_a), 32'(tbl[i].a));
      check($sformatf("v%0d_cmp_b", i),     32'(cmp_b), 32'(tbl[i].b));
      check($sformatf("v%0d_in_ready_res", i), 32'(in_ready), 0);
      handshake();
      check($sformatf("v%0d_res_valid_drop", i), 32'(res_valid), 0);
      check($sformatf("v%0d_in_ready_after", i),  32'(in_ready),  1);
      check($sformatf("v%0d_eq_count", i), 32'(eq_count), 32'(tbl[i].eqc));
      check($sformatf("v%0d_gt_count", i), 32'(gt_count), 32'(tbl[i].gtc));
    end

    // Back-pressure: result held 20 cycles, offered bytes not consumed.
    run_pair(16'h0007, 16'h0007, f, ix, lat);
    check("bp_idx", 32'(ix), 5);
    in_data = 8'hAA; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_valid_c%0d", c),    32'(res_valid), 1);
      check($sformatf("bp_flags_c%0d", c),    32'(res_flags), 32'(7'b1111_011));
      check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready),  0);
    end
    in_valid = 1'b0;
    handshake();
    check("bp_eq_count", 32'(eq_count), 2);

    // Flush after two bytes; a byte offered with flush is also dropped.
    send_byte(8'h99);
    send_byte(8'h88);
    check("flush_cmp_a_held", 32'(cmp_a), 32'h0007);
    flush = 1'b1; in_data = 8'h77; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_eq_count_kept", 32'(eq_count), 2);
    check("flush_gt_count_kept", 32'(gt_count), 1);
    check("flush_cmp_b_held",    32'(cmp_b),    32'h0007);
    run_pair(16'h1234, 16'h1234, f, ix, lat);
    check("flush_cmp_a", 32'(cmp_a), 32'h1234);
    check("flush_cmp_b", 32'(cmp_b), 32'h1234);
    check("flush_idx",   32'(ix),    6);
    handshake();
    check("flush_eq_after", 32'(eq_count), 3);

    // Flush in RESULT beats a simultaneous handshake: result dropped.
    run_pair(16'h0003, 16'h0003, f, ix, lat);
    check("rflush_idx", 32'(ix), 7);
    flush = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; res_ready = 1'b0;
    check("rflush_res_valid", 32'(res_valid), 0);
    check("rflush_eq_count",  32'(eq_count),  3);
    check("rflush_in_ready",  32'(in_ready),  1);
    check("rflush_res_idx",   32'(res_idx),   7);
    run_pair(16'h0100, 16'h0001, f, ix, lat);
    check("rflush_next_idx",   32'(ix), 7);
    check("rflush_next_flags", 32'(f),  32'(7'b1010_100));
    handshake();
    check("rflush_gt_count", 32'(gt_count), 2);

    // Reset asserted mid-SETTLE.
    send_byte(8'h09); send_byte(8'h00); send_byte(8'h09); send_byte(8'h00);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 0);
    run_pair(16'h0009, 16'h0009, f, ix, lat);
    check("midrst_idx",   32'(ix), 0);
    check("midrst_flags", 32'(f),  32'(7'b1111_011));
    handshake();
    check("midrst_eq_count", 32'(eq_count), 1);

    // 257 equal pairs from reset: eq_count saturates, res_idx wraps.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      run_pair(16'(k), 16'(k), f, ix, lat);
      if (k == 1)   check("sat_k1_idx",   32'(ix), 0);
      if (k == 256) check("sat_k256_idx", 32'(ix), 255);
      if (k == 257) check("sat_k257_idx", 32'(ix), 0);
      handshake();
      if (k == 254) check("sat_k254_eq", 32'(eq_count), 254);
      if (k == 255) check("sat_k255_eq", 32'(eq_count), 255);
    end
    check("sat_eq_count", 32'(eq_count), 255);
    check("sat_gt_count", 32'(gt_count), 0);
    check("sat_res_idx",  32'(res_idx),  1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
